bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares one Wishbone-style memory bus between the instruction-fetch port (pc_reg/if_id side) and the data port (mem stage).
- Arbitrates with fixed data priority plus an anti-starvation rule.
- Sequences each single transfer, registers the returned data, and raises a stall request to ctrl while any requester waits.
- Aborts hung transfers with a timeout and signals a bus error for later exception handling.

Parameters:
- TIMEOUT, 255: bus cycles allowed in a grant state before the transfer is aborted. Range 1..255; counter is 8 bits.
- MAX_D_BURST, 2: consecutive data grants allowed while i_req is pending before fetch is forced.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  32  fetch address
- i_rdata  out  32  fetched instruction
- i_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held until d_ack
- d_we  in  1  data write enable
- d_sel  in  4  byte select
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data
- d_ack  out  1  one-cycle data completion pulse
- m_cyc  out  1  bus cycle active
- m_stb  out  1  strobe
- m_we  out  1  bus write enable
- m_sel  out  4  bus byte select
- m_addr  out  32  bus address
- m_wdata  out  32  bus write data
- m_rdata  in  32  bus read data
- m_ack  in  1  slave acknowledge
- stallreq_o  out  1  stall request to ctrl
- bus_err_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset: when rst=0 at a clock edge, all registered outputs become 0 (m_cyc, m_stb, m_we, m_sel, m_addr, m_wdata, i_rdata, d_rdata, i_ack, d_ack, bus_err_o). The FSM goes to IDLE and both counters are cleared. This applies mid-transfer as well; the abandoned transfer produces no ack.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE transitions:
  - If d_req=1 and not (i_req=1 and dcnt==MAX_D_BURST): go to GRANT_D and dcnt += 1.
  - Else if i_req=1: go to GRANT_I and clear dcnt.
  - Else stay in IDLE.
- On entering a grant state, the following are registered from the granted port, with m_cyc=m_stb=1:
  - m_addr, m_we, m_sel, m_wdata.
  - Fetch grants use m_we=0, m_sel=4'b1111, m_wdata=0.
- Address and data are held stable for the whole grant; requester inputs are not resampled.
- In a grant state with m_ack=1:
  - Next cycle m_cyc=m_stb=0.
  - The granted port's rdata <= m_rdata (rdata is loaded for data writes too).
  - The granted port's ack=1 for exactly one cycle.
  - FSM returns to IDLE. Every transfer is followed by one IDLE cycle.
- dcnt is cleared whenever d_req=0 in IDLE, so the burst limit counts only back-to-back data grants.
- Timeout:
  - tcnt increments every cycle in a grant state and clears in IDLE.
  - If tcnt reaches TIMEOUT-1 with m_ack=0, next cycle: m_cyc=m_stb=0, the granted port's ack=1 with rdata=0, bus_err_o=1, FSM to IDLE.
  - If m_ack and the timeout occur in the same cycle, m_ack wins and there is no error.
- m_ack in IDLE is ignored.
- Latency: a request sampled in IDLE at cycle 0 gives m_stb=1 in cycle 1. If m_ack=1 in cycle k, the ack and rdata appear in cycle k+1. The minimum is 2 cycles request-to-ack.
- stallreq_o is combinational: (i_req & ~i_ack) | (d_req & ~d_ack). It is 0 while rst=0.
- A requester that drops req mid-grant does not cancel the transfer; it completes and the ack still pulses.
- i_ack and d_ack are never both 1 in the same cycle.

Decomposition:
- defines.v receives:
  - state encodings ArbIdle, ArbGrantI, ArbGrantD (2-bit);
  - TimeoutCntBus [7:0];
  - ArbRstEnable 1'b0.
- RegBus and InstAddrBus are reused for address and data widths.
- No sub-module: the FSM, the two counters and the output registers fit comfortably in one module.

Test Plan:
- Only i_req=1, i_addr=0x00000004; slave acks 1 cycle after stb with rdata=0x34011100 -> m_addr=0x4 at cycle 1, i_ack and i_rdata=0x34011100 at cycle 3, stallreq_o=1 during cycles 0-2.
- i_req and d_req asserted together in IDLE; d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_sel=0xF -> GRANT_D first with m_we=1 and m_wdata=0xDEADBEEF; after d_ack, the next grant is fetch.
- d_req held high continuously with i_req high, zero-wait slave -> grant order D, D, I, D, D, I (MAX_D_BURST=2).
- TIMEOUT=4, d_req with the slave never acking -> m_stb high exactly 4 cycles, then d_ack=1, d_rdata=0, bus_err_o=1 for one cycle, FSM in IDLE.
- rst=0 asserted during GRANT_I with m_ack pending -> next cycle all outputs 0, no i_ack. After release, a pending i_req restarts the fetch from IDLE.
- m_ack=1 while in IDLE -> no ack and no state change.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared encodings and widths for the instruction/data bus arbiter.
package bus_arbiter_pkg;

    localparam int RegBus        = 32;
    localparam int InstAddrBus   = 32;
    localparam int TimeoutCntBus = 8;

    localparam logic ArbRstEnable = 1'b0;

    typedef enum logic [1:0] {
        ArbIdle   = 2'b00,
        ArbGrantI = 2'b01,
        ArbGrantD = 2'b10
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter.sv
// Single-master Wishbone-style bus shared by fetch and data ports: data has
// priority, fetch is forced after MAX_D_BURST back-to-back data grants.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT     = 255,
    parameter int MAX_D_BURST = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_req,
    input  logic [InstAddrBus-1:0] i_addr,
    output logic [RegBus-1:0]      i_rdata,
    output logic                   i_ack,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [3:0]             d_sel,
    input  logic [RegBus-1:0]      d_addr,
    input  logic [RegBus-1:0]      d_wdata,
    output logic [RegBus-1:0]      d_rdata,
    output logic                   d_ack,
    output logic                   m_cyc,
    output logic                   m_stb,
    output logic                   m_we,
    output logic [3:0]             m_sel,
    output logic [RegBus-1:0]      m_addr,
    output logic [RegBus-1:0]      m_wdata,
    input  logic [RegBus-1:0]      m_rdata,
    input  logic                   m_ack,
    output logic                   stallreq_o,
    output logic                   bus_err_o
);

    localparam logic [TimeoutCntBus-1:0] TimeoutLast = TimeoutCntBus'(TIMEOUT - 1);
    localparam logic [TimeoutCntBus-1:0] MaxBurst    = TimeoutCntBus'(MAX_D_BURST);

    arb_state_e               state_q, state_d;
    logic [TimeoutCntBus-1:0] tcnt_q, tcnt_d;
    logic [TimeoutCntBus-1:0] dcnt_q, dcnt_d;
    logic                     m_cyc_q, m_cyc_d;
    logic                     m_we_q, m_we_d;
    logic [3:0]               m_sel_q, m_sel_d;
    logic [RegBus-1:0]        m_addr_q, m_addr_d;
    logic [RegBus-1:0]        m_wdata_q, m_wdata_d;
    logic [RegBus-1:0]        i_rdata_q, i_rdata_d;
    logic [RegBus-1:0]        d_rdata_q, d_rdata_d;
    logic                     i_ack_q, i_ack_d;
    logic                     d_ack_q, d_ack_d;
    logic                     bus_err_q, bus_err_d;
    logic                     burst_full;

    assign burst_full = (dcnt_q == MaxBurst);

    always_comb begin
        state_d   = state_q;
        tcnt_d    = '0;
        dcnt_d    = dcnt_q;
        m_cyc_d   = m_cyc_q;
        m_we_d    = m_we_q;
        m_sel_d   = m_sel_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        bus_err_d = 1'b0;
        case (state_q)
            ArbIdle: begin
                if (d_req && !(i_req && burst_full)) begin
                    state_d   = ArbGrantD;
                    // Saturate so a long data-only run cannot wrap the limit check.
                    dcnt_d    = burst_full ? dcnt_q : dcnt_q + 1'b1;
                    m_cyc_d   = 1'b1;
                    m_we_d    = d_we;
                    m_sel_d   = d_sel;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                end else if (i_req) begin
                    state_d   = ArbGrantI;
                    dcnt_d    = '0;
                    m_cyc_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_sel_d   = 4'b1111;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                end else begin
                    dcnt_d = '0;
                end
            end
            ArbGrantI, ArbGrantD: begin
                tcnt_d = tcnt_q + 1'b1;
                // A real acknowledge takes precedence over an expiring timeout.
                if (m_ack || (tcnt_q == TimeoutLast)) begin
                    state_d   = ArbIdle;
                    tcnt_d    = '0;
                    m_cyc_d   = 1'b0;
                    bus_err_d = !m_ack;
                    if (state_q == ArbGrantI) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = m_ack ? m_rdata : '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = m_ack ? m_rdata : '0;
                    end
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == ArbRstEnable) begin
            state_q   <= ArbIdle;
            tcnt_q    <= '0;
            dcnt_q    <= '0;
            m_cyc_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_sel_q   <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            dcnt_q    <= dcnt_d;
            m_cyc_q   <= m_cyc_d;
            m_we_q    <= m_we_d;
            m_sel_q   <= m_sel_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign m_cyc      = m_cyc_q;
    assign m_stb      = m_cyc_q;
    assign m_we       = m_we_q;
    assign m_sel      = m_sel_q;
    assign m_addr     = m_addr_q;
    assign m_wdata    = m_wdata_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign i_ack      = i_ack_q;
    assign d_ack      = d_ack_q;
    assign bus_err_o  = bus_err_q;
    assign stallreq_o = rst & ((i_req & ~i_ack_q) | (d_req & ~d_ack_q));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with TIMEOUT=4 and MAX_D_BURST=2.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_cyc;
    logic        m_stb;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        stallreq_o;
    logic        bus_err_o;

    logic ack_man;
    logic ack_auto;
    int   n_asserts = 0;
    int   n_fail    = 0;

    // Slave model: either a hand-driven ack or a zero-wait ack following stb.
    assign m_ack = ack_man | (ack_auto & m_stb);

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT(4), .MAX_D_BURST(2)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
        .stallreq_o(stallreq_o), .bus_err_o(bus_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] grants[$];
        logic [7:0] exp_g[6];
        int         nstb;

        exp_g = '{8'h44, 8'h44, 8'h49, 8'h44, 8'h44, 8'h49};
        rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_sel = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        ack_man = 1'b0; ack_auto = 1'b0;

        tick(); tick();
        chk("rst_m_cyc", {31'b0, m_cyc}, 32'd0);
        chk("rst_acks", {30'b0, i_ack, d_ack}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err_o}, 32'd0);
        rst = 1'b1;
        tick();

        // Single fetch, slave acks one cycle after stb
        i_req = 1'b1; i_addr = 32'h4; #1;
        chk("f_stall_c0", {31'b0, stallreq_o}, 32'd1);
        tick();
        chk("f_stb_c1", {31'b0, m_stb}, 32'd1);
        chk("f_addr_c1", m_addr, 32'h4);
        chk("f_sel_we_c1", {27'b0, m_sel, m_we}, {27'b0, 4'hF, 1'b0});
        tick();
        ack_man = 1'b1; m_rdata = 32'h34011100; #1;
        chk("f_stall_c2", {31'b0, stallreq_o}, 32'd1);
        chk("f_noack_c2", {31'b0, i_ack}, 32'd0);
        tick();
        chk("f_ack_c3", {31'b0, i_ack}, 32'd1);
        chk("f_rdata_c3", i_rdata, 32'h34011100);
        chk("f_stb_c3", {31'b0, m_stb}, 32'd0);
        chk("f_stall_c3", {31'b0, stallreq_o}, 32'd0);
        i_req = 1'b0; ack_man = 1'b0;
        tick();
        chk("f_ack_c4", {31'b0, i_ack}, 32'd0);

        // Simultaneous requests: data first, then fetch
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_sel = 4'hF;
        tick();
        chk("p_we", {31'b0, m_we}, 32'd1);
        chk("p_addr", m_addr, 32'h100);
        chk("p_wdata", m_wdata, 32'hDEADBEEF);
        chk("p_sel", {28'b0, m_sel}, 32'hF);
        ack_man = 1'b1; m_rdata = 32'h11111111;
        tick();
        chk("p_acks", {30'b0, i_ack, d_ack}, 32'd1);
        chk("p_d_rdata", d_rdata, 32'h11111111);
        d_req = 1'b0; d_we = 1'b0; ack_man = 1'b0;
        tick();
        chk("p_i_stb", {31'b0, m_stb}, 32'd1);
        chk("p_i_addr", m_addr, 32'h8);
        chk("p_i_wdata", m_wdata, 32'd0);
        ack_man = 1'b1; m_rdata = 32'h22222222;
        tick();
        chk("p_i_ack", {30'b0, i_ack, d_ack}, 32'd2);
        chk("p_i_rdata", i_rdata, 32'h22222222);
        i_req = 1'b0; ack_man = 1'b0;
        tick();

        // Continuous requests with a zero-wait slave: D,D,I,D,D,I
        ack_auto = 1'b1; m_rdata = 32'h5555AAAA;
        i_req = 1'b1; i_addr = 32'hC;
        d_req = 1'b1; d_addr = 32'h200; d_sel = 4'h3;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i_ack && d_ack) chk("b_both_ack", 32'd1, 32'd0);
            if (m_stb) grants.push_back((m_addr == 32'hC) ? 8'h49 : 8'h44);
        end
        chk("b_count", grants.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("b_grant%0d", i),
                (i < grants.size()) ? {24'b0, grants[i]} : 32'd0, {24'b0, exp_g[i]});
        end
        i_req = 1'b0; d_req = 1'b0; ack_auto = 1'b0;
        tick();

        // Timeout: slave never acks
        m_rdata = 32'hAAAA5555;
        d_req = 1'b1; d_addr = 32'h300; nstb = 0;
        for (int i = 0; i < 20 && !d_ack; i++) begin
            tick();
            if (m_stb) nstb++;
        end
        chk("t_d_ack", {31'b0, d_ack}, 32'd1);
        chk("t_stb_cycles", nstb, 32'd4);
        chk("t_d_rdata", d_rdata, 32'd0);
        chk("t_bus_err", {31'b0, bus_err_o}, 32'd1);
        chk("t_stb_off", {31'b0, m_stb}, 32'd0);
        d_req = 1'b0;
        tick();
        chk("t_err_pulse", {30'b0, bus_err_o, d_ack}, 32'd0);

        // Reset in the middle of a fetch grant with ack pending
        i_req = 1'b1; i_addr = 32'h10;
        tick();
        chk("r_stb_before", {31'b0, m_stb}, 32'd1);
        ack_man = 1'b1; m_rdata = 32'h77777777; rst = 1'b0;
        tick();
        chk("r_outs", {28'b0, m_cyc, m_stb, i_ack, stallreq_o}, 32'd0);
        chk("r_addr", m_addr, 32'd0);
        chk("r_i_rdata", i_rdata, 32'd0);
        rst = 1'b1; ack_man = 1'b0;
        tick();
        chk("r_restart_stb", {31'b0, m_stb}, 32'd1);
        chk("r_restart_addr", m_addr, 32'h10);
        chk("r_no_ack", {31'b0, i_ack}, 32'd0);
        ack_man = 1'b1;
        tick();
        chk("r_ack", {31'b0, i_ack}, 32'd1);
        chk("r_rdata", i_rdata, 32'h77777777);
        i_req = 1'b0;
        tick();

        // Stray ack while idle
        tick(); tick();
        chk("idle_acks", {29'b0, i_ack, d_ack, bus_err_o}, 32'd0);
        chk("idle_cyc", {31'b0, m_cyc}, 32'd0);
        ack_man = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
